// File: rtl/projeto_sem_bcd.sv
// ----------------------------------------------------------------------------
// projeto_sem_bcd
//
// Price-computing core of the retail scale. It takes a net weight in grams
// and a unit price in cents per kg. It produces the binary display fields
// that feed the display encoder. This core has no BCD conversion stage.
//
// Pipeline (two register stages; throughput of one sample per cycle):
//   stage 0 : both inputs are clamped to IN_MAX (combinational)
//   stage 1 : registers the clamped weight w, the clamped price c and the
//             exact product P = w*c
//   stage 2 : registers all six output fields, derived by constant
//             division and modulo
//
// Ports:
//   clk                          in   1     system clock, rising edge
//   rst                          in   1     asynchronous reset, active-high
//   weightInGrams                in   W_IN  net weight in grams
//   centimos                     in   W_IN  unit price in cents per kg
//   Peso_Final_unidades          out  W_IN  weight, whole kg
//   Peso_Final_decimal           out  W_IN  weight, remaining grams (0..999)
//   Preco_Por_Kg_Parte_Inteira   out  W_IN  unit price, whole euros
//   Preco_Por_Kg_Parte_Decimal   out  W_IN  unit price, cents (0..99)
//   Preco_Parte_Inteira          out  W_IN  total price, whole euros
//   Preco_Parte_Decimal          out  W_IN  total price, cents (0..99)
//
// Build option:
//   ROUND_HALF_UP_EN  defined   : total cents T = (P + 500) / 1000
//                     undefined : total cents T = P / 1000 (truncation)
// ----------------------------------------------------------------------------
module projeto_sem_bcd #(
    parameter int unsigned W_IN   = 14,
    parameter int unsigned IN_MAX = 9999
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_IN-1:0] weightInGrams,
    input  logic [W_IN-1:0] centimos,
    output logic [W_IN-1:0] Peso_Final_unidades,
    output logic [W_IN-1:0] Peso_Final_decimal,
    output logic [W_IN-1:0] Preco_Por_Kg_Parte_Inteira,
    output logic [W_IN-1:0] Preco_Por_Kg_Parte_Decimal,
    output logic [W_IN-1:0] Preco_Parte_Inteira,
    output logic [W_IN-1:0] Preco_Parte_Decimal
);

    // Product width: exact for two W_IN-bit operands.
    localparam int unsigned PW = 2 * W_IN;

    localparam logic [W_IN-1:0] SAT_MAX      = W_IN'(IN_MAX);
    localparam logic [W_IN-1:0] GRAMS_PER_KG = W_IN'(1000);
    localparam logic [W_IN-1:0] CENTS_PER_EU = W_IN'(100);
    localparam logic [PW-1:0]   P_DIV        = PW'(1000);
    localparam logic [PW-1:0]   P_HALF       = PW'(500);
    localparam logic [PW-1:0]   T_DIV        = PW'(100);

    // ------------------------------------------------------------------
    // Stage 0: input saturation
    // ------------------------------------------------------------------
    logic [W_IN-1:0] w_sat;
    logic [W_IN-1:0] c_sat;

    always_comb begin
        w_sat = weightInGrams;
        c_sat = centimos;
        if (weightInGrams > SAT_MAX) begin
            w_sat = SAT_MAX;
        end
        if (centimos > SAT_MAX) begin
            c_sat = SAT_MAX;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register the clamped operands and their exact product
    // ------------------------------------------------------------------
    logic [W_IN-1:0] w_q, w_d;
    logic [W_IN-1:0] c_q, c_d;
    logic [PW-1:0]   p_q, p_d;

    always_comb begin
        w_d = w_sat;
        c_d = c_sat;
        p_d = PW'(w_sat) * PW'(c_sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            c_q <= '0;
            p_q <= '0;
        end else begin
            w_q <= w_d;
            c_q <= c_d;
            p_q <= p_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: constant division / modulo into display fields
    // ------------------------------------------------------------------
    logic [PW-1:0] t_cents;

    always_comb begin
`ifdef ROUND_HALF_UP_EN
        // The clamped inputs bound P + 500 to about 1e8, so the sum
        // cannot wrap in PW bits.
        t_cents = (p_q + P_HALF) / P_DIV;
`else
        t_cents = p_q / P_DIV;
`endif
    end

    logic [W_IN-1:0] kg_d, g_d, eur_kg_d, cnt_kg_d, eur_d, cnt_d;

    // The clamp limits T to 99980, so both quotient and remainder by 100
    // fit in W_IN bits. The narrowing casts drop only zero bits.
    always_comb begin
        kg_d     = w_q / GRAMS_PER_KG;
        g_d      = w_q % GRAMS_PER_KG;
        eur_kg_d = c_q / CENTS_PER_EU;
        cnt_kg_d = c_q % CENTS_PER_EU;
        eur_d    = W_IN'(t_cents / T_DIV);
        cnt_d    = W_IN'(t_cents % T_DIV);
    end

    logic [W_IN-1:0] kg_q, g_q, eur_kg_q, cnt_kg_q, eur_q, cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kg_q     <= '0;
            g_q      <= '0;
            eur_kg_q <= '0;
            cnt_kg_q <= '0;
            eur_q    <= '0;
            cnt_q    <= '0;
        end else begin
            kg_q     <= kg_d;
            g_q      <= g_d;
            eur_kg_q <= eur_kg_d;
            cnt_kg_q <= cnt_kg_d;
            eur_q    <= eur_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Peso_Final_unidades        = kg_q;
    assign Peso_Final_decimal         = g_q;
    assign Preco_Por_Kg_Parte_Inteira = eur_kg_q;
    assign Preco_Por_Kg_Parte_Decimal = cnt_kg_q;
    assign Preco_Parte_Inteira        = eur_q;
    assign Preco_Parte_Decimal        = cnt_q;

endmodule

// File: tb/tb_projeto_sem_bcd.sv
// ----------------------------------------------------------------------------
// tb_projeto_sem_bcd
//
// Directed bench for projeto_sem_bcd. It uses hand-computed expected values.
// Each task drives one scenario and compares the six output fields, packed
// in port order: {kg, g, eur/kg, cents/kg, eur, cents}.
// ----------------------------------------------------------------------------
module tb_projeto_sem_bcd;

    localparam int unsigned W = 14;

    logic         clk;
    logic         rst;
    logic [W-1:0] weightInGrams;
    logic [W-1:0] centimos;
    logic [W-1:0] pf_u, pf_d, pk_i, pk_d, pr_i, pr_d;

    int unsigned n_checks;
    int unsigned n_fail;

    projeto_sem_bcd #(
        .W_IN   (14),
        .IN_MAX (9999)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .weightInGrams              (weightInGrams),
        .centimos                   (centimos),
        .Peso_Final_unidades        (pf_u),
        .Peso_Final_decimal         (pf_d),
        .Preco_Por_Kg_Parte_Inteira (pk_i),
        .Preco_Por_Kg_Parte_Decimal (pk_d),
        .Preco_Parte_Inteira        (pr_i),
        .Preco_Parte_Decimal        (pr_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6*W-1:0] outs();
        return {pf_u, pf_d, pk_i, pk_d, pr_i, pr_d};
    endfunction

    function automatic logic [6*W-1:0] pack(input int a, input int b, input int c,
                                            input int d, input int e, input int f);
        return {W'(a), W'(b), W'(c), W'(d), W'(e), W'(f)};
    endfunction

    // Drive inputs just after an edge, then sample 1 time unit after the
    // second edge.
    task automatic drive_and_wait(input int w, input int c);
        weightInGrams = W'(w);
        centimos      = W'(c);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6*W-1:0] exp_v;
        exp_v = '0;
        rst = 1'b1;
        weightInGrams = W'(1500);
        centimos      = W'(470);
        #2;
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", outs(), exp_v);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_held_with_clock: got %h expected %h", outs(), exp_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [6*W-1:0] exp_v;
        drive_and_wait(1500, 470);
        exp_v = pack(1, 500, 4, 70, 7, 5);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL basic_1500_470: got %h expected %h", outs(), exp_v);
        end
        // P = 100000 -> T = 100
        drive_and_wait(1000, 100);
        exp_v = pack(1, 0, 1, 0, 1, 0);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL basic_1000_100: got %h expected %h", outs(), exp_v);
        end
        // P = 3996001 -> T = 3996 in both rounding modes
        drive_and_wait(1999, 1999);
        exp_v = pack(1, 999, 19, 99, 39, 96);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL basic_1999_1999: got %h expected %h", outs(), exp_v);
        end
    endtask

    task automatic test_saturation();
        logic [6*W-1:0] exp_v;
        drive_and_wait(16383, 16000);
        exp_v = pack(9, 999, 99, 99, 999, 80);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL saturation_max: got %h expected %h", outs(), exp_v);
        end
        // Exactly at the ceiling: no clamping; same result.
        drive_and_wait(9999, 9999);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL saturation_edge_9999: got %h expected %h", outs(), exp_v);
        end
    endtask

    task automatic test_rounding();
        logic [6*W-1:0] exp_v;
        // P = 500 -> T = 1 rounded, 0 truncated
        drive_and_wait(1, 500);
`ifdef ROUND_HALF_UP_EN
        exp_v = pack(0, 1, 5, 0, 0, 1);
`else
        exp_v = pack(0, 1, 5, 0, 0, 0);
`endif
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL rounding_1_500: got %h expected %h", outs(), exp_v);
        end
        // P = 1500 -> T = 2 rounded, 1 truncated
        drive_and_wait(3, 500);
`ifdef ROUND_HALF_UP_EN
        exp_v = pack(0, 3, 5, 0, 0, 2);
`else
        exp_v = pack(0, 3, 5, 0, 0, 1);
`endif
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL rounding_3_500: got %h expected %h", outs(), exp_v);
        end
    endtask

    task automatic test_zero_weight();
        logic [6*W-1:0] exp_v;
        drive_and_wait(0, 1234);
        exp_v = pack(0, 0, 12, 34, 0, 0);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL zero_weight: got %h expected %h", outs(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [6*W-1:0] exp_v;
        weightInGrams = W'(1500);
        centimos      = W'(470);
        @(posedge clk);               // edge 1
        #1;
        weightInGrams = W'(250);
        centimos      = W'(1000);
        @(posedge clk);               // edge 2
        #1;
        exp_v = pack(1, 500, 4, 70, 7, 5);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back_edge2: got %h expected %h", outs(), exp_v);
        end
        @(posedge clk);               // edge 3
        #1;
        exp_v = pack(0, 250, 10, 0, 2, 50);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back_edge3: got %h expected %h", outs(), exp_v);
        end
    endtask

    task automatic test_reset_midstream();
        logic [6*W-1:0] exp_v;
        drive_and_wait(1500, 470);
        #2;                           // between edges
        rst = 1'b1;
        #1;
        exp_v = '0;
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_midstream_async: got %h expected %h", outs(), exp_v);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);               // first edge after release
        #1;
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release_edge1: got %h expected %h", outs(), exp_v);
        end
        @(posedge clk);               // second edge after release
        #1;
        exp_v = pack(1, 500, 4, 70, 7, 5);
        n_checks++;
        if (outs() !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release_edge2: got %h expected %h", outs(), exp_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_zero_weight();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
